// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU-side request/response signals and the data-memory port
// used by mem_access_unit. The slave modport is the unit itself; the master
// modport is the CPU plus memory environment that surrounds it.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misalign;
  logic [31:0] dm_address;
  logic [31:0] dm_data_in;
  logic        dm_mem_write;
  logic [31:0] dm_data_out;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, dm_data_out,
    output rdata, done, misalign, dm_address, dm_data_in, dm_mem_write
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, dm_data_out,
    input  rdata, done, misalign, dm_address, dm_data_in, dm_mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU and a word-wide data memory.
// Adds byte/halfword loads with sign/zero extension and byte/halfword
// stores through read-modify-write. Completion is a one-cycle done strobe.
//
// Build option: define MEMU_MISALIGN_TRAP_EN to abort misaligned accesses
// with misalign=1. Without it, misaligned accesses are silently aligned
// down (word -> addr[1:0]=00, half -> addr[0]=0) and run normally.
module mem_access_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic              clock,
  input  logic              reset,   // synchronous, active-low
  mem_access_unit_if.slave  bus
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [31:0] WORD_MASK = ADDR_MASK & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        mis_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic        req_word, req_half, req_mis;
  logic        word_q, half_q;
  logic [1:0]  lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Request classification; size 11 is reserved and behaves as a word.
  assign req_word = bus.size[1];
  assign req_half = (bus.size == 2'b01);
`ifdef MEMU_MISALIGN_TRAP_EN
  assign req_mis  = (req_word && (bus.addr[1:0] != 2'b00)) ||
                    (req_half && bus.addr[0]);
`else
  assign req_mis  = 1'b0;
`endif

  assign word_q = size_q[1];
  assign half_q = (size_q == 2'b01);
  // Lane offset with the alignment bits a word/half access cannot use forced
  // to zero, so untrapped misaligned accesses fall back to the aligned lane.
  assign lane   = word_q ? 2'b00 : (half_q ? {addr_q[1], 1'b0} : addr_q[1:0]);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (req_mis)                state_d = DONE;
          else if (bus.we && req_word) state_d = WR;
          else                        state_d = RD;
        end
      end
      RD:   state_d = we_q ? WR : DONE;
      WR:   state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction from the memory word for loads.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b        = bus.dm_data_out[{lane, 3'b000} +: 8];
    h        = bus.dm_data_out[{lane[1], 4'b0000} +: 16];
    load_val = bus.dm_data_out;
    if (half_q)       load_val = {{16{sign_q & h[15]}}, h};
    else if (!word_q) load_val = {{24{sign_q & b[7]}}, b};
  end

  // Read-modify-write merge: replace the target lane of the captured word.
  always_comb begin
    merged = merge_q;
    if (half_q)       merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
    else if (!word_q) merged[{lane, 3'b000} +: 8]      = wdata_q[7:0];
  end

  // Request latch, merge capture and load result register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            sign_q  <= bus.sign_ext;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            mis_q   <= req_mis;
          end
        end
        RD: begin
          if (we_q) merge_q <= bus.dm_data_out;
          else      rdata_q <= load_val;
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobe, abort flag, memory port.
  always_comb begin
    bus.rdata        = rdata_q;
    bus.done         = (state_q == DONE);
    bus.misalign     = (state_q == DONE) && mis_q;
    bus.dm_address   = addr_q & WORD_MASK;
    bus.dm_mem_write = (state_q == WR) && reset;
    bus.dm_data_in   = '0;
    if (state_q == WR) bus.dm_data_in = word_q ? wdata_q : merged;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte-array reference model predicts
// load results, memory contents, latency and write counts; a negedge
// compare process checks the DUT every cycle against those predictions.
module tb_mem_access_unit;

`ifdef MEMU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(4096)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory: combinational read, word-only synchronous write.
  logic [31:0] mem [0:1023];
  assign bus.dm_data_out = mem[bus.dm_address[11:2]];
  always @(posedge clock)
    if (bus.dm_mem_write) mem[bus.dm_address[11:2]] <= bus.dm_data_in;

  // Reference model: plain byte-addressed memory.
  logic [7:0] ref_mem [0:4095];
  logic [31:0] model_rdata = '0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz[1] ? 4 : (sz == 2'b01 ? 2 : 1);
  endfunction

  function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] m;
    m = a & 32'h0000_0FFF;
    if (!TRAP) m = m & ~32'(nbytes(sz) - 1);
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sx);
    logic [31:0] m, v;
    int n;
    m = eff_addr(a, sz);
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[m + 32'(i)]) << (8 * i));
    if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    logic [31:0] dd;
    m  = eff_addr(a, sz);
    dd = d;
    for (int i = 0; i < nbytes(sz); i++) begin
      ref_mem[m + 32'(i)] = dd[7:0];
      dd = dd >> 8;
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  // Expectation for the access in flight.
  bit          chk_en  = 1'b0;
  bit          pending = 1'b0;
  int          cyc, wr_cnt, exp_lat, exp_wr;
  logic [31:0] exp_rdata;
  bit          exp_mis;
  bit          exp_done;

  // Per-cycle compare process.
  always @(negedge clock) begin
    if (chk_en) begin
      if (pending) cyc++;
      exp_done = pending && (cyc == exp_lat);
      if (bus.dm_mem_write) wr_cnt++;
      check("done", bus.done, exp_done);
      check("misalign", bus.misalign, exp_done ? exp_mis : 1'b0);
      if (!pending) check("idle_write", bus.dm_mem_write, 1'b0);
      if (exp_done) begin
        check("rdata", bus.rdata, exp_rdata);
        check("write_cycles", wr_cnt, exp_wr);
        pending = 1'b0;
      end
    end
  end

  task automatic do_op(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] d);
    logic [31:0] m;
    bit mis;
    int idx;
    m   = a & 32'h0000_0FFF;
    mis = (sz[1] && m[1:0] != 2'b00) || (sz == 2'b01 && m[0]);
    exp_mis = TRAP && mis;
    if (exp_mis) begin
      exp_lat = 1; exp_wr = 0;
    end else if (!w) begin
      exp_lat = 2; exp_wr = 0;
      model_rdata = model_load(a, sz, sx);
    end else begin
      exp_lat = sz[1] ? 2 : 3; exp_wr = 1;
      model_store(a, sz, d);
    end
    exp_rdata = model_rdata;
    @(negedge clock); #1;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = d;
    cyc = 0; wr_cnt = 0; pending = 1'b1;
    @(posedge clock); #1;
    // Scramble the inputs: the in-flight access must use latched values.
    bus.req = 1'b0; bus.addr = ~a; bus.wdata = ~d; bus.size = ~sz; bus.sign_ext = ~sx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); #2;
      if (!pending) break;
    end
    if (pending) begin
      check("timeout", 32'(pending), 32'd0);
      pending = 1'b0;
    end
    idx = int'(eff_addr(a, sz) >> 2);
    check("mem_word", mem[idx], model_word(idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_done", bus.done, 1'b0);
    check("rst_misalign", bus.misalign, 1'b0);
    check("rst_write", bus.dm_mem_write, 1'b0);
    check("rst_address", bus.dm_address, 32'h0);
    check("rst_data_in", bus.dm_data_in, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    chk_en = 1'b1;

    do_op(1'b1, 2'b10, 1'b0, 32'h010, 32'h1122_3344);         // sw
    check("pin_sw", mem[4], 32'h1122_3344);
    do_op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);                 // lw
    check("pin_lw", bus.rdata, 32'h1122_3344);
    do_op(1'b1, 2'b00, 1'b0, 32'h011, 32'h0000_00AA);         // sb
    check("pin_sb", mem[4], 32'h1122_AA44);
    do_op(1'b0, 2'b00, 1'b1, 32'h011, 32'h0);                 // lb
    check("pin_lb", bus.rdata, 32'hFFFF_FFAA);
    do_op(1'b0, 2'b00, 1'b0, 32'h011, 32'h0);                 // lbu
    check("pin_lbu", bus.rdata, 32'h0000_00AA);
    do_op(1'b0, 2'b01, 1'b1, 32'h012, 32'h0);                 // lh
    check("pin_lh", bus.rdata, 32'h0000_1122);
    do_op(1'b1, 2'b01, 1'b0, 32'h012, 32'h0000_8001);         // sh
    check("pin_sh", mem[4], 32'h8001_AA44);
    do_op(1'b0, 2'b01, 1'b1, 32'h012, 32'h0);                 // lh
    check("pin_lh2", bus.rdata, 32'hFFFF_8001);
    do_op(1'b0, 2'b01, 1'b0, 32'h012, 32'h0);                 // lhu
    check("pin_lhu", bus.rdata, 32'h0000_8001);
    do_op(1'b0, 2'b00, 1'b1, 32'h013, 32'h0);                 // lb top lane
    check("pin_lb3", bus.rdata, 32'hFFFF_FF80);

    do_op(1'b1, 2'b10, 1'b0, 32'h013, 32'hDEAD_BEEF);         // misaligned sw
    check("pin_mis_sw", mem[4], TRAP ? 32'h8001_AA44 : 32'hDEAD_BEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);                // wrap-around lw
    check("pin_wrap", bus.rdata, TRAP ? 32'h8001_AA44 : 32'hDEAD_BEEF);
    do_op(1'b0, 2'b01, 1'b1, 32'h011, 32'h0);                 // misaligned lh
    do_op(1'b0, 2'b11, 1'b0, 32'h010, 32'h0);                 // reserved size as word
    do_op(1'b1, 2'b00, 1'b0, 32'hFFF, 32'h1234_565A);         // sb last byte
    do_op(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0);                 // lbu last byte
    check("pin_last", bus.rdata, 32'h0000_005A);

    // Reset during RD of a byte store: no write, no done, rdata cleared.
    @(negedge clock); #1;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h010; bus.wdata = 32'h0000_0077;
    @(posedge clock); #1;
    bus.req = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_rdata", bus.rdata, 32'h0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_mem", mem[4], model_word(4));
    @(negedge clock);
    reset = 1'b1;
    model_rdata = '0;
    repeat (3) @(negedge clock);
    do_op(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);                 // still usable

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the multi-cycle CPU control/datapath and the word-wide data memory.
- The data memory has a combinational read, a word-only synchronous write, and a word index taken from address bits above bit 1.
- This block adds byte and halfword loads with sign/zero extension, and byte/halfword stores via read-modify-write.
- It performs alignment checking and drives a single-cycle done strobe back to the CPU FSM.

Parameters:
- MEM_BYTES, 4096: data memory size in bytes, a power of two. Address bits at or above log2(MEM_BYTES) are ignored (wrap-around).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load; latched with req
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address; latched with req
- wdata  in  32  store data; low byte/half used for sub-word stores; latched with req
- rdata  out  32  load result register (MDR)
- done  out  1  one-cycle pulse when the access completes
- misalign  out  1  valid with done; 1 = access aborted as misaligned
- dm_address  out  32  to memory: {latched addr masked to MEM_BYTES-1, bits[1:0] = 00}
- dm_data_in  out  32  to memory write data
- dm_mem_write  out  1  to memory write enable
- dm_data_out  in  32  from memory read data (combinational on dm_address)

Behaviour:
- Reset (reset=0 at an edge): state = IDLE; rdata = 0; done = 0; misalign = 0; latched fields = 0.
- dm_mem_write = (state==WR) AND reset. No memory write ever occurs on an edge where reset=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - req=1 latches we, size, sign_ext, addr, wdata.
  - Misaligned request (word with addr[1:0]≠0, or half with addr[0]≠0): go to DONE with misalign pending. No memory access; rdata unchanged.
  - Load, or byte/half store: go to RD.
  - Word store: go to WR.
- RD (dm_address valid):
  - Load: extract the lane and update rdata at the end of RD, then go to DONE.
  - Byte lane = addr[1:0]: 0 → bits[7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24] (little-endian).
  - Half lane = addr[1]: 0 → [15:0], 1 → [31:16].
  - Extension per sign_ext.
  - Sub-word store: capture dm_data_out into a merge register, then go to WR.
- WR: dm_data_in = wdata (word store) or the merge register with the target lane replaced by wdata[7:0] or wdata[15:0]. Asserts the write; next state DONE.
- DONE: done=1 for exactly this cycle; misalign reflects the abort condition; next state IDLE.
- misalign = 0 whenever done = 0.
- Latency from the req-accept edge, counting done cycles:
  - load: 2 (RD, DONE)
  - word store: 2 (WR, DONE)
  - sub-word store: 3 (RD, WR, DONE)
  - misaligned: 1 (DONE)
- req while not IDLE is ignored, with no queuing. req held high through DONE is re-accepted on the first IDLE cycle after it.
- Changes to addr/wdata/size after acceptance do not affect the in-flight access.
- Reset during RD or WR: abort, go to IDLE, no write, done stays 0, rdata reset to 0.
- dm_data_in = 0 and dm_address = latched value outside WR/RD.

Optional Feature:
- Macro: MEMU_MISALIGN_TRAP_EN.
- Defined: misalignment detection as described above.
- Not defined: misalign tied to 0. Misaligned word accesses force addr[1:0]=00 and misaligned half accesses force addr[0]=0 for lane selection, and proceed normally with normal latency.

Test Plan:
- Word store/load:
  - Stimulus: sw 0x11223344 to 0x010.
  - Required: dm_mem_write high exactly 1 cycle; done 2 cycles after accept.
  - Stimulus: lw 0x010.
  - Required: rdata=0x11223344 with done, misalign=0.
- Byte store and loads:
  - Stimulus: sb wdata=0x000000AA to 0x011.
  - Required: memory word = 0x1122AA44; RD, WR, DONE sequence.
  - Stimulus: lb 0x011. Required: 0xFFFFFFAA.
  - Stimulus: lbu 0x011. Required: 0x000000AA.
- Halfword:
  - Stimulus: lh 0x012. Required: 0x00001122.
  - Stimulus: sh 0x8001 to 0x012, then lh 0x012.
  - Required: word = 0x8001AA44; lh returns 0xFFFF8001.
- Misalign (macro defined):
  - Stimulus: sw to 0x013.
  - Required: done+misalign 1 cycle after accept; dm_mem_write never asserted; rdata unchanged.
  - Macro undefined, same stimulus: word at 0x010 is written, misalign=0.
- Reset mid-op and wrap:
  - Stimulus: reset=0 during RD of an sb.
  - Required: no write; IDLE next; rdata=0; done never pulses.
  - Stimulus: lw 0x1010 with MEM_BYTES=4096. Required: returns word 0x010.
